// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : shared types and frame constants for the SPI memory slave  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int WR_FRAME_BITS = 17;
  localparam int RD_FRAME_BITS = 9;
  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    RX        = 3'd2,
    WR_COMMIT = 3'd3,
    RD_WAIT   = 3'd4,
    RD_READY  = 3'd5,
    TX        = 3'd6,
    DRAIN     = 3'd7
  } spi_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return ({24'd0, addr} < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_mem_array : MEM_DEPTH x 8 storage, sync write, comb read         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spi_mem_array
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/spi_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_mem_slave : clk-synchronous SPI slave fronting a small byte store |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spi_mem_slave
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int RD_DELAY  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic err
);

  localparam int         c_IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [4:0] c_RD_LAST  = 5'(RD_FRAME_BITS - 1);
  localparam logic [4:0] c_WR_LAST  = 5'(WR_FRAME_BITS - 1);
  localparam logic [3:0] c_RD_DELAY = 4'(RD_DELAY);

  spi_state_e                 r_state, n_state;
  logic [4:0]                 r_bit_cnt, n_bit_cnt;
  logic [WR_FRAME_BITS-1:0]   r_shift, n_shift;
  logic [DATA_W-1:0]          r_rdata, n_rdata;
  logic [3:0]                 r_dcnt, n_dcnt;
  logic                       r_cs_seen, n_cs_seen;
  logic                       r_err, n_err;

  logic [ADDR_W-1:0]          w_rd_addr;
  logic [ADDR_W-1:0]          w_wr_addr;
  logic [DATA_W-1:0]          w_wr_data;
  logic [DATA_W-1:0]          w_mem_rdata;
  logic                       w_mem_we;

  // Read address completes on the edge that samples bit 8, so take it from mosi directly
  assign w_rd_addr = {mosi, r_shift[7:1]};
  assign w_wr_addr = r_shift[8:1];
  assign w_wr_data = r_shift[16:9];
  assign w_mem_we  = (r_state == WR_COMMIT) && addr_in_range(w_wr_addr, MEM_DEPTH);

  spi_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (c_IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_mem_we),
    .waddr (w_wr_addr[c_IDX_W-1:0]),
    .wdata (w_wr_data),
    .raddr (w_rd_addr[c_IDX_W-1:0]),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rdata   <= '0;
      r_dcnt    <= '0;
      r_cs_seen <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= n_state;
      r_bit_cnt <= n_bit_cnt;
      r_shift   <= n_shift;
      r_rdata   <= n_rdata;
      r_dcnt    <= n_dcnt;
      r_cs_seen <= n_cs_seen;
      r_err     <= n_err;
    end
  end

  always_comb begin
    n_state   = r_state;
    n_bit_cnt = r_bit_cnt;
    n_shift   = r_shift;
    n_rdata   = r_rdata;
    n_dcnt    = r_dcnt;
    n_cs_seen = r_cs_seen;
    n_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!cs) begin
          n_state   = ARM;
          n_bit_cnt = '0;
          n_shift   = '0;
        end
      end
      ARM: begin
        if (cs) begin
          n_err   = 1'b1;
          n_shift = '0;
          n_state = IDLE;
        end else begin
          n_shift[0] = mosi;
          n_bit_cnt  = 5'd1;
          n_state    = RX;
        end
      end
      RX: begin
        if (cs) begin
          n_err     = 1'b1;
          n_shift   = '0;
          n_bit_cnt = '0;
          n_state   = IDLE;
        end else begin
          n_shift[r_bit_cnt] = mosi;
          n_bit_cnt          = r_bit_cnt + 5'd1;
          if (!r_shift[0] && r_bit_cnt == c_RD_LAST) begin
            n_state   = RD_WAIT;
            n_bit_cnt = '0;
            n_cs_seen = 1'b0;
            n_dcnt    = '0;
            n_rdata   = addr_in_range(w_rd_addr, MEM_DEPTH) ? w_mem_rdata : '0;
            n_err     = !addr_in_range(w_rd_addr, MEM_DEPTH);
          end else if (r_shift[0] && r_bit_cnt == c_WR_LAST) begin
            n_state   = WR_COMMIT;
            n_bit_cnt = '0;
            n_err     = !addr_in_range(w_wr_addr, MEM_DEPTH);
          end
        end
      end
      WR_COMMIT: n_state = DRAIN;
      DRAIN: begin
        if (cs) n_state = IDLE;
      end
      RD_WAIT: begin
        // Once cs is seen high the delay runs regardless of cs
        if (!r_cs_seen) begin
          if (cs) begin
            if (c_RD_DELAY == 4'd0) begin
              n_state = RD_READY;
            end else begin
              n_cs_seen = 1'b1;
              n_dcnt    = 4'd1;
            end
          end
        end else if (r_dcnt == c_RD_DELAY) begin
          n_state = RD_READY;
        end else begin
          n_dcnt = r_dcnt + 4'd1;
        end
      end
      RD_READY: begin
        n_state   = TX;
        n_bit_cnt = '0;
      end
      TX: begin
        n_bit_cnt = r_bit_cnt + 5'd1;
        if (r_bit_cnt == 5'd7) begin
          n_state   = IDLE;
          n_bit_cnt = '0;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  assign miso    = (r_state == TX) ? r_rdata[r_bit_cnt[2:0]] : 1'b0;
  assign ready   = (r_state == RD_READY);
  assign op_done = (r_state == WR_COMMIT);
  assign err     = r_err;

endmodule
`default_nettype wire
